sudoku_display_driver: RTL

- Consumer end of the interface controller's display outputs: takes the current board row (four hex digits) and the one-hot cursor, and drives four seven-segment displays.
- Blanks empty cells and blinks the cursor cell.
- Shows an underscore cursor when the cursor cell is empty.
- All outputs are registered. Sits between the interface controller and the board's HEX3..HEX0 pins.

---
 rtl/sudoku_pkg.sv | 39 +++
 rtl/sudoku_display_driver_hex_to_seg.sv | 12 +
 rtl/sudoku_display_driver.sv | 90 +++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared widths, blink FSM states and the seven-segment glyph table for the
// sudoku display path. Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package sudoku_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int ROW_W      = DIGIT_W * NUM_DIGITS;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK      = 7'h00;
  localparam logic [SEG_W-1:0] SEG_UNDERSCORE = 7'h08;

  typedef enum logic {HIDE = 1'b0, SHOW = 1'b1} blink_e;

  function automatic logic [SEG_W-1:0] glyphOf(input logic [DIGIT_W-1:0] val);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (val)
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sudoku_display_driver_hex_to_seg.sv
// Combinational hex digit to active-high seven-segment glyph; 0 is an empty
// cell and renders blank.
import sudoku_pkg::*;

module hex_to_seg (
  input  logic [DIGIT_W-1:0] val,
  output logic [SEG_W-1:0]   seg
);

  always_comb seg = glyphOf(val);

endmodule

// File: rtl/sudoku_display_driver.sv
// Drives HEX3..HEX0 from the current board row: blanks empty cells, blinks the
// one-hot cursor cell and shows an underscore when that cell is empty.
import sudoku_pkg::*;

module sudoku_display_driver #(
  parameter int BLINK_HALF     = 25000000,
  parameter int CNT_W          = 25,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ROW_W-1:0]      currentRow,
  input  logic [NUM_DIGITS-1:0] currentNum,
  output logic [SEG_W-1:0]      HEX3,
  output logic [SEG_W-1:0]      HEX2,
  output logic [SEG_W-1:0]      HEX1,
  output logic [SEG_W-1:0]      HEX0,
  output logic                  blinkPhase
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(BLINK_HALF - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  blink_e                               state;
  logic [CNT_W-1:0]                     cnt;
  logic [NUM_DIGITS-1:0]                numPrev;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     glyph;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     hexD;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     hexQ;
  logic                                 cursorOk;
  logic                                 restart;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      hex_to_seg uSeg (
        .val (currentRow[i*DIGIT_W +: DIGIT_W]),
        .seg (glyph[i])
      );
    end
  endgenerate

  // Only an exactly one-hot value selects a cursor; anything else renders steady.
  assign cursorOk = (currentNum != '0) &&
                    ((currentNum & (currentNum - NUM_DIGITS'(1))) == '0);
  assign restart  = (currentNum != numPrev);

  always_comb begin
    hexD = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [SEG_W-1:0] seg;
      seg = glyph[i];
      if (cursorOk && currentNum[i]) begin
        if (state == HIDE)
          seg = SEG_BLANK;
        else if (currentRow[i*DIGIT_W +: DIGIT_W] == '0)
          seg = SEG_UNDERSCORE;
      end
      hexD[i] = SEG_ACTIVE_LOW ? ~seg : seg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= SHOW;
      cnt     <= '0;
      numPrev <= '0;
      hexQ    <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      numPrev <= currentNum;
      hexQ    <= hexD;
      // A moved cursor wins over terminal count so it is visible at once.
      if (restart) begin
        state <= SHOW;
        cnt   <= '0;
      end else if (cnt == TERM_CNT) begin
        state <= (state == SHOW) ? HIDE : SHOW;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign HEX3       = hexQ[3];
  assign HEX2       = hexQ[2];
  assign HEX1       = hexQ[1];
  assign HEX0       = hexQ[0];
  assign blinkPhase = (state == SHOW);

endmodule
